// File: rtl/adder_tree_pkg.sv
// adder_tree_pkg
// Shared constants and types for adder_tree and adder_tree_feeder.
//   W        word and sum width
//   N        lane count (power of two, >= 2)
//   LAT      tree latency, one registered adder level per stage
//   word_t   one lane / sum word
//   cnt_t    frame word count, 0..N
//   idx_t    lane index, 0..N-1
//   lat_t    latency down-counter, 0..LAT
package adder_tree_pkg;
    localparam int W        = 32;
    localparam int N        = 64;
    localparam int LAT      = $clog2(N);
    localparam int IDX_W    = $clog2(N);
    localparam int CNT_W    = $clog2(N + 1);
    localparam int LATCNT_W = $clog2(LAT + 1);

    typedef logic [W-1:0]        word_t;
    typedef logic [CNT_W-1:0]    cnt_t;
    typedef logic [IDX_W-1:0]    idx_t;
    typedef logic [LATCNT_W-1:0] lat_t;

    typedef enum logic [1:0] {
        FILL,
        WAIT,
        HOLD
    } feed_state_e;
endpackage

// File: rtl/adder_tree.sv
// adder_tree
// Pipelined binary adder tree, LAT registered levels, wrap-around sums.
//   clk   clock
//   din   N lane words, sampled every cycle
//   sum   sum of the din vector sampled LAT cycles earlier
// Nodes are laid out as a heap: node i has children 2i and 2i+1, and
// children with index >= N are the input lanes. All leaves sit at the same
// depth because N is a power of two, so every path has exactly LAT registers.
// The pipeline has no reset; the feeder never captures a sum it did not time.
module adder_tree
    import adder_tree_pkg::*;
(
    input  logic  clk,
    input  word_t din [0:N-1],
    output word_t sum
);
    word_t node_reg [1:N-1];

    always_ff @(posedge clk) begin
        for (int i = N / 2; i < N; i++) begin
            node_reg[i] <= din[2*i-N] + din[2*i+1-N];
        end
        for (int i = 1; i < N / 2; i++) begin
            node_reg[i] <= node_reg[2*i] + node_reg[2*i+1];
        end
    end

    assign sum = node_reg[1];
endmodule

// File: rtl/lane_buffer.sv
// lane_buffer
// N x W lane register driven straight onto the tree inputs.
//   clk, rst   clock, asynchronous active-high reset (clears all lanes)
//   wr_en      write wr_data into lane wr_idx
//   wr_idx     lane to write
//   wr_data    word to write
//   clr        zero every lane (takes priority over a write)
//   lanes      current lane contents
module lane_buffer
    import adder_tree_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  wr_en,
    input  idx_t  wr_idx,
    input  word_t wr_data,
    input  logic  clr,
    output word_t lanes [0:N-1]
);
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        word_t lane_reg;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                lane_reg <= '0;
            end else if (clr) begin
                lane_reg <= '0;
            end else if (wr_en && (wr_idx == idx_t'(gi))) begin
                lane_reg <= wr_data;
            end
        end

        assign lanes[gi] = lane_reg;
    end
endmodule

// File: rtl/adder_tree_feeder.sv
// adder_tree_feeder
// Packs up to N input words into the tree lane vector, waits out the tree
// latency, then offers the captured sum downstream. One frame in flight.
//   clk, rst                    clock, asynchronous active-high reset
//   s_valid/s_ready/s_data/s_last   input word stream
//   tree_din                    lane vector to the tree
//   tree_sum                    tree result
//   m_valid/m_ready/m_sum/m_count   result stream (sum and word count)
module adder_tree_feeder
    import adder_tree_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  s_valid,
    output logic  s_ready,
    input  word_t s_data,
    input  logic  s_last,
    output word_t tree_din [0:N-1],
    input  word_t tree_sum,
    output logic  m_valid,
    input  logic  m_ready,
    output word_t m_sum,
    output cnt_t  m_count
);
    feed_state_e state_reg;
    idx_t        idx_reg;
    lat_t        lat_cnt_reg;
    cnt_t        count_reg;
    logic        m_valid_reg;
    word_t       m_sum_reg;
    cnt_t        m_count_reg;

    logic in_hs;
    logic frame_end;
    logic out_hs;
    logic clr_lanes;

    // Ready depends on state only, so no input-to-ready combinational path.
    assign s_ready   = (state_reg == FILL);
    assign in_hs     = s_valid && s_ready;
    assign frame_end = in_hs && (s_last || (idx_reg == idx_t'(N - 1)));
    assign out_hs    = m_valid_reg && m_ready;
    assign clr_lanes = (state_reg == HOLD) && out_hs;

    lane_buffer u_lanes (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (in_hs),
        .wr_idx  (idx_reg),
        .wr_data (s_data),
        .clr     (clr_lanes),
        .lanes   (tree_din)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= FILL;
            idx_reg     <= '0;
            lat_cnt_reg <= '0;
            count_reg   <= '0;
            m_valid_reg <= 1'b0;
            m_sum_reg   <= '0;
            m_count_reg <= '0;
        end else begin
            case (state_reg)
                FILL: begin
                    if (in_hs) begin
                        idx_reg <= idx_reg + 1'b1;
                        if (frame_end) begin
                            count_reg   <= cnt_t'(idx_reg) + cnt_t'(1);
                            lat_cnt_reg <= lat_t'(LAT);
                            state_reg   <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // The launch cycle is the first WAIT cycle; the sum of
                    // that launch is on tree_sum when the counter reaches 0.
                    if (lat_cnt_reg == '0) begin
                        m_sum_reg   <= tree_sum;
                        m_count_reg <= count_reg;
                        m_valid_reg <= 1'b1;
                        state_reg   <= HOLD;
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg - 1'b1;
                    end
                end
                HOLD: begin
                    if (out_hs) begin
                        m_valid_reg <= 1'b0;
                        idx_reg     <= '0;
                        state_reg   <= FILL;
                    end
                end
                default: state_reg <= FILL;
            endcase
        end
    end

    assign m_valid = m_valid_reg;
    assign m_sum   = m_sum_reg;
    assign m_count = m_count_reg;
endmodule

// File: tb/tb_adder_tree_feeder.sv
module tb_adder_tree_feeder;
    import adder_tree_pkg::*;

    logic  clk = 1'b0;
    logic  rst;
    logic  s_valid;
    logic  s_ready;
    word_t s_data;
    logic  s_last;
    word_t tree_din [0:N-1];
    word_t tree_sum;
    logic  m_valid;
    logic  m_ready;
    word_t m_sum;
    cnt_t  m_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    adder_tree_feeder dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .tree_din (tree_din),
        .tree_sum (tree_sum),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_sum    (m_sum),
        .m_count  (m_count)
    );

    adder_tree u_tree (
        .clk (clk),
        .din (tree_din),
        .sum (tree_sum)
    );

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic word_t lanes_or(input int lo, input int hi);
        word_t acc = '0;
        for (int i = lo; i <= hi; i++) acc |= tree_din[i];
        return acc;
    endfunction

    // Offer one word and hold it until the feeder takes it.
    task automatic send_word(input word_t d, input logic last);
        int guard = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        while (!s_ready && guard < 200) begin
            step();
            guard++;
        end
        if (!s_ready) check("s_ready_timeout", s_ready, 1'b1);
        step();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input word_t w[$], input logic mark_last, input int max_gap);
        for (int i = 0; i < w.size(); i++) begin
            int gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
            repeat (gap) step();
            send_word(w[i], mark_last && (i == w.size() - 1));
        end
    endtask

    task automatic wait_result(output int n);
        n = 0;
        while (!m_valid && n < 100) begin
            step();
            n++;
        end
        if (!m_valid) check("m_valid_timeout", m_valid, 1'b1);
    endtask

    // Wait for the result, optionally stall, take it, and check turnaround.
    task automatic collect(input string tag, input word_t es, input cnt_t ec,
                           input int elat, input int stall);
        int n;
        m_ready = (stall == 0);
        wait_result(n);
        if (elat >= 0) check({tag, "_latency"}, n, elat);
        repeat (stall) step();
        m_ready = 1'b1;
        check({tag, "_sum"}, m_sum, es);
        check({tag, "_count"}, m_count, ec);
        $display("frame %s: sum=%0h count=%0d", tag, m_sum, m_count);
        step();
        check({tag, "_s_ready_next"}, s_ready, 1'b1);
        check({tag, "_m_valid_drop"}, m_valid, 1'b0);
    endtask

    initial begin
        word_t frame[$];
        word_t exp_sums[$];
        cnt_t  exp_cnts[$];
        longint total;
        int len;
        int n;
        logic stale_seen;

        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
        step(); step();
        check("reset_s_ready", s_ready, 1'b1);
        check("reset_m_valid", m_valid, 1'b0);
        check("reset_m_sum", m_sum, '0);
        check("reset_m_count", m_count, '0);
        check("reset_lanes", lanes_or(0, N - 1), '0);
        rst = 1'b0;
        step();

        // Full frame 1..N without s_last.
        frame.delete();
        total = 0;
        for (int i = 1; i <= N; i++) begin
            frame.push_back(word_t'(i));
            total += i;
        end
        send_frame(frame, 1'b0, 0);
        collect("full_1toN", word_t'(total), cnt_t'(N), LAT + 1, 0);

        // Short frame {5,7,9}; unused lanes stay zero during WAIT.
        frame = '{32'd5, 32'd7, 32'd9};
        send_frame(frame, 1'b1, 0);
        check("short_lane0", tree_din[0], 32'd5);
        check("short_lane1", tree_din[1], 32'd7);
        check("short_lane2", tree_din[2], 32'd9);
        check("short_upper_zero", lanes_or(3, N - 1), '0);
        collect("short3", 32'd21, cnt_t'(3), LAT + 1, 0);

        // Wrap-around: N copies of all-ones, s_last on the N-th word.
        frame.delete();
        total = 0;
        for (int i = 0; i < N; i++) begin
            frame.push_back(32'hFFFF_FFFF);
            total += 64'h0000_0000_FFFF_FFFF;
        end
        send_frame(frame, 1'b1, 0);
        collect("wrap", word_t'(total), cnt_t'(N), LAT + 1, 0);

        // Backpressure in HOLD with a word offered throughout.
        m_ready = 1'b0;
        frame = '{32'd100, 32'd200, 32'd300};
        send_frame(frame, 1'b1, 0);
        wait_result(n);
        s_valid = 1'b1; s_data = 32'd777; s_last = 1'b1;
        for (int c = 0; c < 10; c++) begin
            check("hold_m_valid", m_valid, 1'b1);
            check("hold_m_sum", m_sum, 32'd600);
            check("hold_m_count", m_count, cnt_t'(3));
            check("hold_s_ready", s_ready, 1'b0);
            step();
        end
        m_ready = 1'b1;
        s_valid = 1'b0; s_last = 1'b0;
        step();
        check("hold_release_s_ready", s_ready, 1'b1);
        check("hold_release_m_valid", m_valid, 1'b0);
        check("hold_lanes_cleared", lanes_or(0, N - 1), '0);
        $display("frame hold: stalled 10 cycles, released");

        // Reset during WAIT: everything returns to reset values at once.
        frame = '{32'd1, 32'd2, 32'd3};
        send_frame(frame, 1'b1, 0);
        step(); step();
        rst = 1'b1;
        #1;
        check("midrst_m_valid", m_valid, 1'b0);
        check("midrst_m_sum", m_sum, '0);
        check("midrst_m_count", m_count, '0);
        check("midrst_s_ready", s_ready, 1'b1);
        check("midrst_lanes", lanes_or(0, N - 1), '0);
        step();
        rst = 1'b0;
        stale_seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            stale_seen |= m_valid;
            step();
        end
        check("midrst_no_stale", stale_seen, 1'b0);
        frame = '{32'd42};
        send_frame(frame, 1'b1, 0);
        collect("single42", 32'd42, cnt_t'(1), LAT + 1, 0);

        // Random back-to-back frames with gapped s_valid and occasional stalls.
        for (int f = 0; f < 25; f++) begin
            len = ($urandom_range(0, 3) == 0) ? N : $urandom_range(1, N);
            frame.delete();
            total = 0;
            for (int i = 0; i < len; i++) begin
                word_t w = $urandom;
                frame.push_back(w);
                total += longint'(w);
            end
            exp_sums.push_back(word_t'(total));
            exp_cnts.push_back(cnt_t'(len));
            send_frame(frame, (len < N) ? 1'b1 : 1'(($urandom_range(0, 1))), 2);
            collect($sformatf("rand%0d", f), exp_sums.pop_front(), exp_cnts.pop_front(),
                    -1, $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/adder_tree_feeder.md
# adder_tree_feeder

Front-end and result collector for the pipelined `adder_tree`. It accepts a stream of W-bit words over a valid/ready handshake and packs up to N of them into a lane vector. Unused lanes are zero-padded. It presents the vector to the tree for one launch, counts the tree's LAT-cycle pipeline latency, then captures the returned sum and offers it downstream with its own valid/ready handshake. There is one frame in flight at a time.

## Interface
- `W`, default 32: word and sum width.
- `N`, default 64: number of lanes. Must be a power of two and at least 2.
- `LAT`, default 6: tree latency in cycles. Must equal log2(N), one registered adder level per stage.
- `clk`  in  1  sole clock. All logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `s_valid`  in  1  input word valid.
- `s_ready`  out  1  feeder accepts a word.
- `s_data`  in  W  input word.
- `s_last`  in  1  marks the last word of a frame, qualified by the input handshake.
- `tree_din`  out  W x [0:N-1]  lane vector driven to the tree's `din`.
- `tree_sum`  in  W  tree `sum` output.
- `m_valid`  out  1  result valid.
- `m_ready`  in  1  downstream accepts the result.
- `m_sum`  out  W  registered frame sum.
- `m_count`  out  clog2(N+1)  number of words in the frame, 1..N.

## Operation
- The FSM has three states: FILL, WAIT and HOLD. Reset state is FILL.
- **FILL**
  - `s_ready`=1.
  - On a handshake (`s_valid` & `s_ready`), `s_data` is written to lane `idx` and `idx` increments.
  - The frame ends when `s_last`=1 or `idx`=N-1 on the handshake.
  - At frame end, the word count is latched and the state moves to WAIT with `lat_cnt`=LAT.
  - Lanes not written keep their value of 0.
- **WAIT**
  - `s_ready`=0.
  - `lat_cnt` decrements by 1 each cycle.
  - When `lat_cnt`=0: `m_sum`←`tree_sum`, `m_count`←latched count, `m_valid`←1, and the state moves to HOLD.
- **HOLD**
  - `s_ready`=0.
  - `m_sum` and `m_count` are stable while `m_valid`=1.
  - On `m_valid` & `m_ready`:
    - `m_valid`←0.
    - All lanes are zeroed and `idx`←0.
    - The state moves to FILL.
- `tree_din` is the lane register and is stable from frame end until HOLD exits.
- Arithmetic is wrap-around modulo 2^W, inherited from the tree. There is no saturation and no overflow flag.
- An N-th word with `s_last`=1 is treated the same as a full frame.
- `s_last` on the first word gives `m_count`=1.
- `s_valid` outside FILL is ignored. The source must hold its data, per the standard valid/ready rule.
- Reset mid-frame, in any state:
  - The partial frame and any pending result are discarded.
  - Stale sums still in the tree pipeline are never captured, because the counter restarts only from a new frame end.

## Timing
- Reset values:
  - `s_ready`=1.
  - `m_valid`=0.
  - `m_sum`=0.
  - `m_count`=0.
  - All `tree_din` lanes are 0.
  - `idx`=0 and `lat_cnt`=0.
- Cycle sequence for a frame whose last word is accepted in cycle L:
  - L+1: launch cycle. The tree samples `tree_din`.
  - L+1+LAT: `tree_sum` is valid and is captured at the end of this cycle.
  - L+2+LAT: `m_valid` rises.
  - Input-to-output latency is therefore LAT+1 cycles after the last handshake.
- After the output handshake in cycle H, `s_ready`=1 in cycle H+1. There is no same-cycle turnaround.
- `s_ready` is decoded from the state only. It has no combinational path from any input.
- The full-rate frame period is k + LAT + 2 cycles minimum for a k-word frame, with `m_ready` held at 1.

## Structure
- Package `adder_tree_pkg`:
  - Constants `W`, `N`, `LAT` (LAT = $clog2(N)).
  - `word_t` = logic [W-1:0].
  - `cnt_t` = logic [$clog2(N+1)-1:0].
  - Enum `feed_state_e` {FILL, WAIT, HOLD}.
- `adder_tree_feeder` imports this package. `adder_tree` should use the same constants.
- The natural sub-module is `lane_buffer`: the N×W register with indexed write, clear-all and async reset. It is the only wide storage.
- The FSM and the latency counter stay in the top module.
- The bench instantiates `adder_tree_feeder` connected to the real `adder_tree`.

## Test plan
- Reset, then 64 words 1..64 with no `s_last`, `m_ready`=1:
  - `m_sum`=2080 and `m_count`=64.
  - `m_valid` rises exactly 7 cycles after the 64th handshake.
- Frame of 3 words {5, 7, 9} with `s_last` on the 9:
  - `m_sum`=21 and `m_count`=3.
  - Lanes 3..63 read 0 during WAIT.
- 64 words of 32'hFFFF_FFFF:
  - `m_sum`=32'hFFFF_FFC0, wrap-around with no flag.
- `m_ready`=0 for 10 cycles in HOLD, with `s_valid`=1 throughout:
  - `m_sum` and `m_count` are stable.
  - `s_ready`=0 and no words are taken.
  - After `m_ready`=1, `s_ready` rises the next cycle.
- `rst` pulsed during WAIT, then the single-word frame {42} with `s_last`:
  - Outputs return to reset values immediately.
  - No stale result appears.
  - Next result is `m_sum`=42, `m_count`=1.
- Randomly gapped `s_valid` with back-to-back frames, compared against a scoreboard:
  - Each sum matches the frame's modulo-2^32 sum.
  - Counts and order are preserved.
